// File: rtl/serial_digit_adder.sv
// serial_digit_adder
// Multi-cycle adder/subtractor. The operands are processed DIGIT bits per
// clock, least-significant digit first, and the carry between digits is held
// in a register, so the carry chain in any one cycle is only DIGIT bits long.
// Subtraction is A + ~B + 1: B is inverted when it is loaded and the carry
// register starts at 1. The result and the flags (carry, signed overflow,
// zero) are registered. They change only when an operation completes.
module serial_digit_adder #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic             zero
);

    // Number of digit cycles, and a counter wide enough to hold N-1
    // (at least one bit wide, so that N = 1 still works).
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q,  state_d;
    logic [WIDTH-1:0]   a_q,      a_d;
    logic [WIDTH-1:0]   b_q,      b_d;
    logic [WIDTH-1:0]   res_q,    res_d;
    logic               carry_q,  carry_d;
    logic [CW-1:0]      cnt_q,    cnt_d;
    logic [WIDTH-1:0]   sum_q,    sum_d;
    logic               c_out_q,  c_out_d;
    logic               ovf_q,    ovf_d;
    logic               zero_q,   zero_d;
    logic               busy_q,   busy_d;
    logic               done_q,   done_d;

    // Digit-slice datapath signals
    logic [DIGIT-1:0]   dig_a_s;
    logic [DIGIT-1:0]   dig_b_s;
    logic [DIGIT:0]     dig_total_s;
    logic [DIGIT-1:0]   dig_sum_s;
    logic               dig_cout_s;
    logic               msb_cin_s;
    logic [WIDTH-1:0]   res_next_s;

    // Digit adder: add the low digit of A and B with the carry register.
    // The carry into the top bit of the digit is recovered from that bit's
    // sum, which gives the carry into the MSB on the last digit.
    always_comb begin
        dig_a_s     = a_q[DIGIT-1:0];
        dig_b_s     = b_q[DIGIT-1:0];
        dig_total_s = {1'b0, dig_a_s} + {1'b0, dig_b_s} + {{DIGIT{1'b0}}, carry_q};
        dig_sum_s   = dig_total_s[DIGIT-1:0];
        dig_cout_s  = dig_total_s[DIGIT];
        msb_cin_s   = dig_a_s[DIGIT-1] ^ dig_b_s[DIGIT-1] ^ dig_sum_s[DIGIT-1];
        // New digit enters at the top; the older digits move down by DIGIT.
        res_next_s  = WIDTH'({dig_sum_s, res_q} >> DIGIT);
    end

    // Next-state logic for the sequencer, the operand shifters and the result/flag registers
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b ^ {WIDTH{sub}};
                    res_d   = {WIDTH{1'b0}};
                    carry_d = sub;
                    cnt_d   = {CW{1'b0}};
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                res_d   = res_next_s;
                carry_d = dig_cout_s;
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = {CW{1'b0}};
                    sum_d   = res_next_s;
                    c_out_d = dig_cout_s;
                    ovf_d   = msb_cin_s ^ dig_cout_s;
                    zero_d  = (res_next_s == {WIDTH{1'b0}});
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status outputs are registered versions of the upcoming state.
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    // State and datapath registers with a synchronous active-low reset that also discards any in-flight operation
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            res_q   <= {WIDTH{1'b0}};
            carry_q <= 1'b0;
            cnt_q   <= {CW{1'b0}};
            sum_q   <= {WIDTH{1'b0}};
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign sum   = sum_q;
    assign c_out = c_out_q;
    assign ovf   = ovf_q;
    assign zero  = zero_q;

endmodule

// File: tb/tb_serial_digit_adder.sv
// Directed testbench for serial_digit_adder.
// Three instances are used: (16,4) as the main device, (16,16) driven by the
// same 16-bit stimulus, and (8,1) driven by its own 8-bit stimulus.
module tb_serial_digit_adder;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        sub;
    logic [15:0] a16;
    logic [15:0] b16;
    logic        start8;
    logic        sub8;
    logic [7:0]  a8;
    logic [7:0]  b8;

    logic        busy0, done0, c0, v0, z0;
    logic [15:0] sum0;
    logic        busy1, done1, c1, v1, z1;
    logic [15:0] sum1;
    logic        busy2, done2, c2, v2, z2;
    logic [7:0]  sum2;

    int n_cmp = 0;
    int n_err = 0;

    serial_digit_adder #(.WIDTH(16), .DIGIT(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a16), .b(b16),
        .busy(busy0), .done(done0), .sum(sum0), .c_out(c0), .ovf(v0), .zero(z0)
    );

    serial_digit_adder #(.WIDTH(16), .DIGIT(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a16), .b(b16),
        .busy(busy1), .done(done1), .sum(sum1), .c_out(c1), .ovf(v1), .zero(z1)
    );

    serial_digit_adder #(.WIDTH(8), .DIGIT(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8),
        .busy(busy2), .done(done2), .sum(sum2), .c_out(c2), .ovf(v2), .zero(z2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_cmp++;
        if ({busy0, done0, sum0, c0, v0, z0} !== 21'd0) begin
            n_err++;
            $display("FAIL reset_dut0 got busy=%b done=%b sum=%h c=%b v=%b z=%b want all 0",
                     busy0, done0, sum0, c0, v0, z0);
        end
        n_cmp++;
        if ({busy1, done1, sum1, c1, v1, z1} !== 21'd0) begin
            n_err++;
            $display("FAIL reset_dut1 got busy=%b done=%b sum=%h want all 0", busy1, done1, sum1);
        end
        n_cmp++;
        if ({busy2, done2, sum2, c2, v2, z2} !== 13'd0) begin
            n_err++;
            $display("FAIL reset_dut2 got busy=%b done=%b sum=%h want all 0", busy2, done2, sum2);
        end
        rst_n = 1'b1;
        tick();
    endtask

    // One 16-bit operation checked on both the (16,4) and (16,16) devices.
    task automatic run_op16(input string nm, input logic s, input logic [15:0] av,
                            input logic [15:0] bv, input logic [15:0] es,
                            input logic ec, input logic ev, input logic ez);
        int lat0 = 0;
        int lat1 = 0;
        int bcnt = 0;
        int dcnt = 0;
        logic [15:0] rs0 = 16'hxxxx;
        logic [15:0] rs1 = 16'hxxxx;
        logic [2:0]  rf0 = 3'bxxx;
        logic [2:0]  rf1 = 3'bxxx;
        sub = s; a16 = av; b16 = bv; start = 1'b1;
        tick();
        start = 1'b0;
        if (busy0) bcnt++;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (busy0) bcnt++;
            if (done0) begin
                dcnt++;
                if (lat0 == 0) begin
                    lat0 = i; rs0 = sum0; rf0 = {c0, v0, z0};
                end
            end
            if (done1 && lat1 == 0) begin
                lat1 = i; rs1 = sum1; rf1 = {c1, v1, z1};
            end
        end
        n_cmp++;
        if (rs0 !== es) begin
            n_err++; $display("FAIL %s sum16x4 got %h want %h", nm, rs0, es);
        end
        n_cmp++;
        if (rf0 !== {ec, ev, ez}) begin
            n_err++; $display("FAIL %s flags16x4 got c/v/z=%b want %b", nm, rf0, {ec, ev, ez});
        end
        n_cmp++;
        if (lat0 !== 4) begin
            n_err++; $display("FAIL %s latency16x4 got %0d want 4", nm, lat0);
        end
        n_cmp++;
        if (bcnt !== 4 || dcnt !== 1) begin
            n_err++; $display("FAIL %s busy_done16x4 got busy=%0d done=%0d want 4 1", nm, bcnt, dcnt);
        end
        n_cmp++;
        if (rs1 !== es || rf1 !== {ec, ev, ez}) begin
            n_err++; $display("FAIL %s result16x16 got %h %b want %h %b", nm, rs1, rf1, es, {ec, ev, ez});
        end
        n_cmp++;
        if (lat1 !== 1) begin
            n_err++; $display("FAIL %s latency16x16 got %0d want 1", nm, lat1);
        end
    endtask

    // One 8-bit operation checked on the bit-serial (8,1) device.
    task automatic run_op8(input string nm, input logic s, input logic [7:0] av,
                           input logic [7:0] bv, input logic [7:0] es,
                           input logic ec, input logic ev, input logic ez);
        int lat = 0;
        int bcnt = 0;
        logic [7:0] rs = 8'hxx;
        logic [2:0] rf = 3'bxxx;
        sub8 = s; a8 = av; b8 = bv; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        if (busy2) bcnt++;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (busy2) bcnt++;
            if (done2 && lat == 0) begin
                lat = i; rs = sum2; rf = {c2, v2, z2};
            end
        end
        n_cmp++;
        if (rs !== es || rf !== {ec, ev, ez}) begin
            n_err++; $display("FAIL %s result8x1 got %h %b want %h %b", nm, rs, rf, es, {ec, ev, ez});
        end
        n_cmp++;
        if (lat !== 8 || bcnt !== 8) begin
            n_err++; $display("FAIL %s timing8x1 got lat=%0d busy=%0d want 8 8", nm, lat, bcnt);
        end
    endtask

    task automatic test_add();
        run_op16("add_basic", 1'b0, 16'h1234, 16'h0FCD, 16'h2201, 1'b0, 1'b0, 1'b0);
        run_op16("add_wrap",  1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1);
        run_op16("add_ovf",   1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_sub();
        run_op16("sub_zero",   1'b1, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b0, 1'b1);
        run_op16("sub_ovf",    1'b1, 16'h7FFF, 16'hFFFF, 16'h8000, 1'b0, 1'b1, 1'b0);
        run_op16("sub_borrow", 1'b1, 16'h0003, 16'h0007, 16'hFFFC, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_width8();
        run_op8("w8_add_basic",  1'b0, 8'h12, 8'h0F, 8'h21, 1'b0, 1'b0, 1'b0);
        run_op8("w8_add_wrap",   1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1);
        run_op8("w8_add_ovf",    1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0);
        run_op8("w8_sub_zero",   1'b1, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b1);
        run_op8("w8_sub_ovf",    1'b1, 8'h7F, 8'hFF, 8'h80, 1'b0, 1'b1, 1'b0);
        run_op8("w8_sub_borrow", 1'b1, 8'h03, 8'h07, 8'hFC, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_start_ignored();
        int lat = 0;
        logic [15:0] rs = 16'hxxxx;
        sub = 1'b0; a16 = 16'h1111; b16 = 16'h2222; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        a16 = 16'h5555; b16 = 16'h5555; start = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++;
        if (busy0 !== 1'b1) begin
            n_err++; $display("FAIL start_in_run busy got %b want 1", busy0);
        end
        for (int i = 3; i <= 10; i++) begin
            tick();
            if (done0 && lat == 0) begin
                lat = i; rs = sum0;
            end
        end
        n_cmp++;
        if (rs !== 16'h3333 || lat !== 4) begin
            n_err++; $display("FAIL start_in_run result got sum=%h lat=%0d want 3333 4", rs, lat);
        end
    endtask

    task automatic test_back_to_back();
        int lat = 0;
        int held_bad = 0;
        int seen = 0;
        logic [15:0] rs = 16'hxxxx;
        sub = 1'b0; a16 = 16'h0100; b16 = 16'h0200; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            if (seen == 0) begin
                tick();
                if (done0) seen = i;
            end
        end
        n_cmp++;
        if (seen !== 4 || sum0 !== 16'h0300) begin
            n_err++; $display("FAIL b2b_first got lat=%0d sum=%h want 4 0300", seen, sum0);
        end
        // Now sampling inside DONE: hold start so it is accepted here.
        a16 = 16'h0001; b16 = 16'h0001; start = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++;
        if (busy0 !== 1'b1 || done0 !== 1'b0) begin
            n_err++; $display("FAIL b2b_accept got busy=%b done=%b want 1 0", busy0, done0);
        end
        if (sum0 !== 16'h0300) held_bad++;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (done0 && lat == 0) begin
                lat = i; rs = sum0;
            end else if (lat == 0 && sum0 !== 16'h0300) begin
                held_bad++;
            end
        end
        n_cmp++;
        if (held_bad !== 0) begin
            n_err++; $display("FAIL b2b_sum_hold got %0d changed cycles want 0", held_bad);
        end
        n_cmp++;
        if (rs !== 16'h0002 || lat !== 4) begin
            n_err++; $display("FAIL b2b_second got sum=%h lat=%0d want 0002 4", rs, lat);
        end
    endtask

    task automatic test_reset_mid_run();
        int dcnt = 0;
        sub = 1'b0; a16 = 16'h1234; b16 = 16'h1111; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_cmp++;
        if ({busy0, done0, sum0, c0, v0, z0} !== 21'd0) begin
            n_err++;
            $display("FAIL midrun_reset got busy=%b done=%b sum=%h c=%b v=%b z=%b want all 0",
                     busy0, done0, sum0, c0, v0, z0);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done0 || busy0) dcnt++;
        end
        n_cmp++;
        if (dcnt !== 0) begin
            n_err++; $display("FAIL midrun_no_done got %0d active cycles want 0", dcnt);
        end
        run_op16("after_reset", 1'b0, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; sub = 1'b0; a16 = 16'h0000; b16 = 16'h0000;
        start8 = 1'b0; sub8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
        test_reset();
        test_add();
        test_sub();
        test_width8();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
